// File: rtl/pla_misex2_resp_capture.sv
// Response capture for the misex2 PLA: 2-entry output buffer, 18-bit MISR, vector counter.
// Optional parity tracking is enabled with `define PLA_MISEX2_RESP_PARITY_EN.
module pla_misex2_resp_capture #(
  parameter int          NUM_VEC = 256,
  parameter logic [17:0] SEED    = 18'h00000,
  parameter logic [17:0] POLY    = 18'h00081
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [17:0] in_resp,
`ifdef PLA_MISEX2_RESP_PARITY_EN
  input  logic        in_par,
  output logic        out_par,
  output logic        par_err,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [17:0] out_resp,
  output logic [17:0] sig,
  output logic [15:0] vec_cnt,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [15:0] LAST_VEC = 16'(NUM_VEC - 1);
  localparam logic [15:0] MAX_VEC  = 16'(NUM_VEC);

  state_t      state_q;
  logic [17:0] sig_q, sig_d;
  logic [15:0] cnt_q;
  logic [17:0] mem_q [2];
  logic        rd_ptr_q, wr_ptr_q;
  logic [1:0]  occ_q;
  logic        accept, pop;

  assign in_ready  = (state_q == RUN) && (occ_q != 2'd2);
  assign accept    = in_valid & in_ready;
  assign out_valid = (occ_q != 2'd0);
  assign pop       = out_valid & out_ready;
  assign out_resp  = out_valid ? mem_q[rd_ptr_q] : 18'h0;
  assign sig       = sig_q;
  assign vec_cnt   = cnt_q;
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);

  // Shift left, fold the carry-out back through POLY, then mix in the new word.
  assign sig_d = {sig_q[16:0], 1'b0} ^ (sig_q[17] ? POLY : 18'h0) ^ in_resp;

`ifdef PLA_MISEX2_RESP_PARITY_EN
  logic mem_par_q [2];
  logic par_err_q;
  assign out_par = out_valid ? (mem_par_q[rd_ptr_q] ^ (^out_resp)) : 1'b0;
  assign par_err = par_err_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sig_q     <= SEED;
      cnt_q     <= 16'h0;
`ifdef PLA_MISEX2_RESP_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else if (clear) begin
      state_q   <= IDLE;
      sig_q     <= SEED;
      cnt_q     <= 16'h0;
`ifdef PLA_MISEX2_RESP_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q   <= RUN;
            sig_q     <= SEED;
            cnt_q     <= 16'h0;
`ifdef PLA_MISEX2_RESP_PARITY_EN
            par_err_q <= 1'b0;
`endif
          end
        end
        RUN: begin
          if (accept) begin
            sig_q <= sig_d;
            if (cnt_q != MAX_VEC) cnt_q <= cnt_q + 16'd1;
            if (cnt_q == LAST_VEC) state_q <= DONE;
`ifdef PLA_MISEX2_RESP_PARITY_EN
            if (in_par != (^in_resp)) par_err_q <= 1'b1;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Buffer keeps draining outside RUN; only clear or reset flush it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0]  <= 18'h0;
      mem_q[1]  <= 18'h0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      occ_q     <= 2'd0;
`ifdef PLA_MISEX2_RESP_PARITY_EN
      mem_par_q[0] <= 1'b0;
      mem_par_q[1] <= 1'b0;
`endif
    end else if (clear) begin
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      occ_q     <= 2'd0;
    end else begin
      if (accept) begin
        mem_q[wr_ptr_q] <= in_resp;
`ifdef PLA_MISEX2_RESP_PARITY_EN
        mem_par_q[wr_ptr_q] <= in_par;
`endif
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      unique case ({accept, pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

endmodule

// File: tb/tb_pla_misex2_resp_capture.sv
// Directed bench for pla_misex2_resp_capture (NUM_VEC=12, SEED=0, POLY=18'h81).
module tb_pla_misex2_resp_capture;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, clear = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic [17:0] in_resp = 18'h0;
  logic        in_ready, out_valid, busy, done;
  logic [17:0] out_resp, sig;
  logic [15:0] vec_cnt;
`ifdef PLA_MISEX2_RESP_PARITY_EN
  logic        in_par = 1'b0;
  logic        out_par, par_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  pla_misex2_resp_capture #(.NUM_VEC(12), .SEED(18'h00000), .POLY(18'h00081)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_resp(in_resp),
`ifdef PLA_MISEX2_RESP_PARITY_EN
    .in_par(in_par), .out_par(out_par), .par_err(par_err),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_resp(out_resp),
    .sig(sig), .vec_cnt(vec_cnt), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] misr(input logic [17:0] s, input logic [17:0] d);
    return {s[16:0], 1'b0} ^ (s[17] ? 18'h00081 : 18'h0) ^ d;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; step(); clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_resp = 18'h3FFFF;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) rst_n = 1'b1;
      step();
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready cyc%0d got %b exp 0", i, in_ready); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid cyc%0d got %b exp 0", i, out_valid); end
      n_checks++; if (sig !== 18'h0) begin n_fail++; $display("FAIL reset_sig cyc%0d got %h exp 0", i, sig); end
      n_checks++; if (vec_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_vec_cnt cyc%0d got %0d exp 0", i, vec_cnt); end
      n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_done_busy cyc%0d got %b%b exp 00", i, done, busy); end
      n_checks++; if (out_resp !== 18'h0) begin n_fail++; $display("FAIL reset_out_resp cyc%0d got %h exp 0", i, out_resp); end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_misr();
    logic [17:0] words [4];
    logic [17:0] exps  [4];
    words[0] = 18'h00001; words[1] = 18'h00000; words[2] = 18'h20000; words[3] = 18'h00000;
    exps[0]  = 18'h00001; exps[1]  = 18'h00002; exps[2]  = 18'h20004; exps[3]  = 18'h00089;
    out_ready = 1'b1;
    pulse_start();
    n_checks++; if (busy !== 1'b1 || in_ready !== 1'b1) begin n_fail++; $display("FAIL misr_start busy=%b in_ready=%b exp 1 1", busy, in_ready); end
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_resp = words[i];
      step();
      n_checks++; if (sig !== exps[i]) begin n_fail++; $display("FAIL misr_sig%0d got %h exp %h", i, sig, exps[i]); end
      n_checks++; if (out_valid !== 1'b1 || out_resp !== words[i]) begin n_fail++; $display("FAIL misr_out%0d got %b/%h exp 1/%h", i, out_valid, out_resp, words[i]); end
    end
    in_valid = 1'b0;
    step();
    n_checks++; if (vec_cnt !== 16'd4 || out_valid !== 1'b0) begin n_fail++; $display("FAIL misr_end vec_cnt=%0d out_valid=%b exp 4 0", vec_cnt, out_valid); end
    pulse_clear();
    n_checks++; if (sig !== 18'h0 || vec_cnt !== 16'h0 || busy !== 1'b0) begin n_fail++; $display("FAIL misr_clear sig=%h cnt=%0d busy=%b exp 0 0 0", sig, vec_cnt, busy); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    pulse_start();
    in_valid = 1'b1; in_resp = 18'h0AAAA;
    step();
    in_resp = 18'h15555;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_occ1 got %b exp 1", in_ready); end
    step();
    in_resp = 18'h3C3C3;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full cyc%0d got %b exp 0", i, in_ready); end
      n_checks++; if (out_resp !== 18'h0AAAA) begin n_fail++; $display("FAIL bp_hold cyc%0d got %h exp 0aaaa", i, out_resp); end
      n_checks++; if (vec_cnt !== 16'd2) begin n_fail++; $display("FAIL bp_cnt cyc%0d got %0d exp 2", i, vec_cnt); end
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    n_checks++; if (out_valid !== 1'b1 || out_resp !== 18'h15555) begin n_fail++; $display("FAIL bp_drain1 got %b/%h exp 1/15555", out_valid, out_resp); end
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain2 got %b exp 0", out_valid); end
    n_checks++; if (sig !== misr(misr(18'h0, 18'h0AAAA), 18'h15555)) begin n_fail++; $display("FAIL bp_sig got %h exp %h", sig, misr(misr(18'h0, 18'h0AAAA), 18'h15555)); end
    pulse_clear();
  endtask

  task automatic test_full_throughput_and_done();
    logic [17:0] s = 18'h0;
    logic [17:0] w;
    out_ready = 1'b1;
    pulse_start();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL tp_pre_out_valid got %b exp 0", out_valid); end
    for (int i = 0; i < 12; i++) begin
      w = 18'h01000 + 18'(i * 7919);
      s = misr(s, w);
      in_valid = 1'b1; in_resp = w;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL tp_in_ready%0d got %b exp 1", i, in_ready); end
      step();
      n_checks++; if (out_valid !== 1'b1 || out_resp !== w) begin n_fail++; $display("FAIL tp_out%0d got %b/%h exp 1/%h", i, out_valid, out_resp, w); end
      n_checks++; if (vec_cnt !== 16'(i + 1)) begin n_fail++; $display("FAIL tp_cnt%0d got %0d exp %0d", i, vec_cnt, i + 1); end
      n_checks++; if (done !== (i == 11)) begin n_fail++; $display("FAIL tp_done%0d got %b exp %b", i, done, (i == 11)); end
    end
    n_checks++; if (sig !== s) begin n_fail++; $display("FAIL done_sig got %h exp %h", sig, s); end
    n_checks++; if (in_ready !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL done_ready_busy got %b%b exp 00", in_ready, busy); end
    step();
    n_checks++; if (out_valid !== 1'b0 || vec_cnt !== 16'd12 || done !== 1'b1) begin n_fail++; $display("FAIL done_hold ov=%b cnt=%0d done=%b exp 0 12 1", out_valid, vec_cnt, done); end
    in_valid = 1'b0;
    pulse_start();
    n_checks++; if (done !== 1'b0 || busy !== 1'b1 || vec_cnt !== 16'h0 || sig !== 18'h0) begin n_fail++; $display("FAIL restart done=%b busy=%b cnt=%0d sig=%h exp 0 1 0 0", done, busy, vec_cnt, sig); end
    pulse_clear();
  endtask

  task automatic test_clear_priority();
    out_ready = 1'b0;
    pulse_start();
    in_valid = 1'b1; in_resp = 18'h00111; step();
    in_resp = 18'h00222; step();
    clear = 1'b1; start = 1'b1; out_ready = 1'b1; in_resp = 18'h00333;
    step();
    clear = 1'b0; start = 1'b0;
    n_checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL clr_full busy=%b ov=%b exp 0 0", busy, out_valid); end
    n_checks++; if (sig !== 18'h0 || vec_cnt !== 16'h0) begin n_fail++; $display("FAIL clr_full_state sig=%h cnt=%0d exp 0 0", sig, vec_cnt); end
    out_ready = 1'b0; in_valid = 1'b0;
    pulse_start();
    in_valid = 1'b1; in_resp = 18'h00444; step();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL clr_occ1_ready got %b exp 1", in_ready); end
    clear = 1'b1; in_resp = 18'h00555;
    step();
    clear = 1'b0; in_valid = 1'b0;
    n_checks++; if (vec_cnt !== 16'h0 || sig !== 18'h0 || out_valid !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL clr_accept cnt=%0d sig=%h ov=%b done=%b exp 0 0 0 0", vec_cnt, sig, out_valid, done); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_resp = 18'h2F000 + 18'(i);
      if (i == 2) out_ready = 1'b1;
      step();
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || sig !== 18'h0 || vec_cnt !== 16'h0) begin n_fail++; $display("FAIL arst_state busy=%b sig=%h cnt=%0d exp 0 0 0", busy, sig, vec_cnt); end
    n_checks++; if (out_valid !== 1'b0 || out_resp !== 18'h0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL arst_buf ov=%b resp=%h ir=%b exp 0 0 0", out_valid, out_resp, in_ready); end
    step();
    rst_n = 1'b1;
    step();
  endtask

`ifdef PLA_MISEX2_RESP_PARITY_EN
  task automatic test_parity();
    out_ready = 1'b0;
    pulse_start();
    in_valid = 1'b1; in_resp = 18'h00003; in_par = 1'b0; step();
    n_checks++; if (par_err !== 1'b0 || out_par !== 1'b0) begin n_fail++; $display("FAIL par_good err=%b op=%b exp 0 0", par_err, out_par); end
    in_par = 1'b1; step();
    in_valid = 1'b0; in_par = 1'b0;
    n_checks++; if (par_err !== 1'b1) begin n_fail++; $display("FAIL par_err got %b exp 1", par_err); end
    n_checks++; if (sig !== misr(misr(18'h0, 18'h3), 18'h3)) begin n_fail++; $display("FAIL par_sig got %h exp %h", sig, misr(misr(18'h0, 18'h3), 18'h3)); end
    out_ready = 1'b1; step();
    n_checks++; if (out_par !== 1'b1) begin n_fail++; $display("FAIL par_out got %b exp 1", out_par); end
    pulse_clear();
    n_checks++; if (par_err !== 1'b0) begin n_fail++; $display("FAIL par_clear got %b exp 0", par_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_misr();
    test_backpressure();
    test_full_throughput_and_done();
    test_clear_priority();
    test_async_reset();
`ifdef PLA_MISEX2_RESP_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
